// File: rtl/tdm_frame_deinterleave_pkg.sv
// Shared types and defaults for the TDM frame deinterleaver.
// Optional idle timeout is enabled with the TDM_TIMEOUT_EN macro.
package tdm_pkg;

    typedef enum logic {
        HUNT,
        COLLECT
    } state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_NUM_CH = 4;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_frame_deinterleave_if.sv
// Sample-in / frame-out bundle of the TDM frame deinterleaver.
// master drives the beat stream, slave is the deinterleaver.
interface tdm_frame_deinterleave_if
    import tdm_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH
);

    logic                     In_Valid;
    logic                     In_Sof;
    logic [DATA_W-1:0]        In_Data;
    logic [NUM_CH*DATA_W-1:0] Out_Data;
    logic                     Out_Frame_Valid;
    logic                     Sync_Err;
    logic                     Locked;

    modport master (
        output In_Valid, In_Sof, In_Data,
        input  Out_Data, Out_Frame_Valid, Sync_Err, Locked
    );

    modport slave (
        input  In_Valid, In_Sof, In_Data,
        output Out_Data, Out_Frame_Valid, Sync_Err, Locked
    );

endinterface

// File: rtl/tdm_frame_deinterleave.sv
// Gathers NUM_CH TDM slots into a shadow frame and commits it atomically.
// Define TDM_TIMEOUT_EN to drop a frame after TIMEOUT_CYC idle cycles.
module tdm_frame_deinterleave
    import tdm_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = ch_width(NUM_CH)
`ifdef TDM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 16
`endif
) (
    input logic                     Ex_Clock,
    input logic                     Ex_Rst_n,
    tdm_frame_deinterleave_if.slave tdm
);

    localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);

    state_t                   state;
    state_t                   state_n;
    logic [CH_W-1:0]          count;
    logic [CH_W-1:0]          count_n;
    logic                     shadow_we;
    logic [CH_W-1:0]          shadow_idx;
    logic                     commit;
    logic                     err;
    logic                     expire;
    logic [DATA_W-1:0]        shadow [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] data_q;
    logic                     fv_q;
    logic                     err_q;
    logic                     lock_q;

    logic sof;
    assign sof = tdm.In_Sof;

`ifdef TDM_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [IDLE_W-1:0] idle;

    // A beat in the expiring cycle wins because expire requires In_Valid=0.
    assign expire = (state == COLLECT) && !tdm.In_Valid
                    && (idle == IDLE_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge Ex_Clock or negedge Ex_Rst_n) begin
        if (!Ex_Rst_n) begin
            idle <= '0;
        end else if (tdm.In_Valid || state != COLLECT || expire) begin
            idle <= '0;
        end else begin
            idle <= idle + 1'b1;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge Ex_Clock or negedge Ex_Rst_n) begin
        if (!Ex_Rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        count_n    = count;
        shadow_we  = 1'b0;
        shadow_idx = '0;
        commit     = 1'b0;
        err        = 1'b0;
        if (tdm.In_Valid) begin
            unique case (state)
                HUNT: begin
                    if (sof) begin
                        shadow_we = 1'b1;
                        count_n   = CH_W'(1);
                        state_n   = COLLECT;
                    end
                end
                COLLECT: begin
                    unique case (1'b1)
                        sof && count == '0: begin
                            shadow_we = 1'b1;
                            count_n   = CH_W'(1);
                        end
                        sof && count != '0: begin
                            err       = 1'b1;
                            shadow_we = 1'b1;
                            count_n   = CH_W'(1);
                        end
                        !sof && count == '0: begin
                            err     = 1'b1;
                            count_n = '0;
                            state_n = HUNT;
                        end
                        !sof && count == LAST: begin
                            commit  = 1'b1;
                            count_n = '0;
                        end
                        default: begin
                            shadow_we  = 1'b1;
                            shadow_idx = count;
                            count_n    = count + 1'b1;
                        end
                    endcase
                end
                default: state_n = HUNT;
            endcase
        end else if (expire) begin
            err     = 1'b1;
            count_n = '0;
            state_n = HUNT;
        end
    end

    always_ff @(posedge Ex_Clock or negedge Ex_Rst_n) begin
        if (!Ex_Rst_n) begin
            count  <= '0;
            data_q <= '0;
            fv_q   <= 1'b0;
            err_q  <= 1'b0;
            lock_q <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            count <= count_n;
            fv_q  <= commit;
            err_q <= err;
            if (shadow_we) begin
                shadow[shadow_idx] <= tdm.In_Data;
            end
            // Last slot bypasses the shadow so the frame lands in one edge.
            if (commit) begin
                for (int k = 0; k < NUM_CH - 1; k++) begin
                    data_q[k*DATA_W +: DATA_W] <= shadow[k];
                end
                data_q[(NUM_CH-1)*DATA_W +: DATA_W] <= tdm.In_Data;
            end
            if (err) begin
                lock_q <= 1'b0;
            end else if (commit) begin
                lock_q <= 1'b1;
            end
        end
    end

    assign tdm.Out_Data        = data_q;
    assign tdm.Out_Frame_Valid = fv_q;
    assign tdm.Sync_Err        = err_q;
    assign tdm.Locked          = lock_q;

endmodule

// File: tb/tb_tdm_frame_deinterleave.sv
// Table-driven bench with a frame scoreboard for tdm_frame_deinterleave.
// Covers the TDM_TIMEOUT_EN build when the macro is defined.
module tb_tdm_frame_deinterleave;
    import tdm_pkg::*;

    localparam int DW = 16;
    localparam int NC = 4;

    typedef struct {
        logic          v;
        logic          sof;
        logic [DW-1:0] d;
        logic          fv;
        logic          err;
        logic          lk;
        logic [63:0]   fr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tdm_frame_deinterleave_if #(.DATA_W(DW), .NUM_CH(NC)) bus ();

    tdm_frame_deinterleave #(.DATA_W(DW), .NUM_CH(NC)) dut (
        .Ex_Clock(clk),
        .Ex_Rst_n(rst_n),
        .tdm     (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_fr = '0;
    vec_t        tbl[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic sof,
                                input logic [DW-1:0] d, input logic fv,
                                input logic err, input logic lk,
                                input logic [63:0] fr = '0);
        vec_t t;
        t.v = v; t.sof = sof; t.d = d;
        t.fv = fv; t.err = err; t.lk = lk; t.fr = fr;
        return t;
    endfunction

    task automatic beat(input vec_t t, input string tag);
        bus.In_Valid = t.v;
        bus.In_Sof   = t.sof;
        bus.In_Data  = t.d;
        if (t.fv) exp_q.push_back(t.fr);
        @(posedge clk);
        #1;
        chk({tag, ".fv"}, 64'(bus.Out_Frame_Valid), 64'(t.fv));
        chk({tag, ".err"}, 64'(bus.Sync_Err), 64'(t.err));
        chk({tag, ".lock"}, 64'(bus.Locked), 64'(t.lk));
        if (bus.Out_Frame_Valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s.frame got=%h want=none", tag, bus.Out_Data);
            end else begin
                last_fr = exp_q.pop_front();
                chk({tag, ".data"}, bus.Out_Data, last_fr);
            end
        end else begin
            chk({tag, ".hold"}, bus.Out_Data, last_fr);
        end
    endtask

    task automatic idle(input int n, input logic lk, input string tag);
        for (int i = 0; i < n; i++) beat(mk(0, 0, '0, 0, 0, lk), tag);
    endtask

    initial begin
        bus.In_Valid = 1'b0;
        bus.In_Sof   = 1'b0;
        bus.In_Data  = '0;

        // Test 1: single frame after reset
        tbl.push_back(mk(1, 1, 16'h0001, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'hFFFE, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h7FFF, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h8000, 1, 0, 1,
                         64'h8000_7FFF_FFFE_0001));
        // Test 2: back-to-back frames
        tbl.push_back(mk(1, 1, 16'h1000, 0, 0, 1));
        tbl.push_back(mk(1, 0, 16'h1001, 0, 0, 1));
        tbl.push_back(mk(1, 0, 16'h1002, 0, 0, 1));
        tbl.push_back(mk(1, 0, 16'h1003, 1, 0, 1,
                         64'h1003_1002_1001_1000));
        tbl.push_back(mk(1, 1, 16'hA5A5, 0, 0, 1));
        tbl.push_back(mk(1, 0, 16'h5A5A, 0, 0, 1));
        tbl.push_back(mk(1, 0, 16'hFFFF, 0, 0, 1));
        tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 1,
                         64'h0000_FFFF_5A5A_A5A5));
        tbl.push_back(mk(1, 1, 16'h8001, 0, 0, 1));
        tbl.push_back(mk(1, 0, 16'h7FFE, 0, 0, 1));
        tbl.push_back(mk(1, 0, 16'h0100, 0, 0, 1));
        tbl.push_back(mk(1, 0, 16'h00FF, 1, 0, 1,
                         64'h00FF_0100_7FFE_8001));
        // Test 2b: 3 idle cycles between beats
        tbl.push_back(mk(1, 1, 16'h1111, 0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, '0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 16'h2222, 0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, '0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 16'h3333, 0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, '0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 16'h4444, 1, 0, 1,
                         64'h4444_3333_2222_1111));
        tbl.push_back(mk(0, 0, '0, 0, 0, 1));
        // Test 3: early SOF
        tbl.push_back(mk(1, 1, 16'h0001, 0, 0, 1));
        tbl.push_back(mk(1, 0, 16'h0002, 0, 0, 1));
        tbl.push_back(mk(1, 1, 16'h0009, 0, 1, 0));
        tbl.push_back(mk(1, 0, 16'h000A, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h000B, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h000C, 1, 0, 1,
                         64'h000C_000B_000A_0009));
        // Test 4: missing SOF, then resync
        tbl.push_back(mk(1, 0, 16'h0005, 0, 1, 0));
        tbl.push_back(mk(1, 0, 16'h0006, 0, 0, 0));
        tbl.push_back(mk(0, 0, '0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0007, 0, 0, 0));
        tbl.push_back(mk(1, 1, 16'h0021, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0022, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0023, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0024, 1, 0, 1,
                         64'h0024_0023_0022_0021));

        repeat (2) @(posedge clk);
        #1;
        chk("rst.data", bus.Out_Data, 64'h0);
        chk("rst.fv", 64'(bus.Out_Frame_Valid), 64'h0);
        chk("rst.err", 64'(bus.Sync_Err), 64'h0);
        chk("rst.lock", 64'(bus.Locked), 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            beat(tbl[i], $sformatf("v%0d", i));
        end

        // Test 5: reset mid-frame clears outputs at once
        beat(mk(1, 1, 16'h00AA, 0, 0, 1), "mid0");
        beat(mk(1, 0, 16'h00BB, 0, 0, 1), "mid1");
        bus.In_Valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.data", bus.Out_Data, 64'h0);
        chk("mid.fv", 64'(bus.Out_Frame_Valid), 64'h0);
        chk("mid.err", 64'(bus.Sync_Err), 64'h0);
        chk("mid.lock", 64'(bus.Locked), 64'h0);
        last_fr = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        beat(mk(1, 1, 16'h0031, 0, 0, 0), "post0");
        beat(mk(1, 0, 16'h0032, 0, 0, 0), "post1");
        beat(mk(1, 0, 16'h0033, 0, 0, 0), "post2");
        beat(mk(1, 0, 16'h0034, 1, 0, 1, 64'h0034_0033_0032_0031), "post3");

`ifdef TDM_TIMEOUT_EN
        // Test 6: 16 idle cycles expire; a beat on cycle 16 does not
        beat(mk(1, 1, 16'h0051, 0, 0, 1), "to0");
        idle(15, 1, "to_idle");
        beat(mk(0, 0, '0, 0, 1, 0), "to_exp");
        idle(2, 0, "to_hunt");
        beat(mk(1, 1, 16'h0061, 0, 0, 0), "nt0");
        idle(15, 0, "nt_idle");
        beat(mk(1, 0, 16'h0062, 0, 0, 0), "nt1");
        beat(mk(1, 0, 16'h0063, 0, 0, 0), "nt2");
        beat(mk(1, 0, 16'h0064, 1, 0, 1, 64'h0064_0063_0062_0061), "nt3");
`else
        // Long gaps inside a frame are legal without the timeout
        beat(mk(1, 1, 16'h0051, 0, 0, 1), "gap0");
        idle(20, 1, "gap_idle");
        beat(mk(1, 0, 16'h0052, 0, 0, 1), "gap1");
        beat(mk(1, 0, 16'h0053, 0, 0, 1), "gap2");
        beat(mk(1, 0, 16'h0054, 1, 0, 1, 64'h0054_0053_0052_0051), "gap3");
`endif
        idle(2, 1, "tail");

        chk("sb.left", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_frame_deinterleave.md
Name: tdm_frame_deinterleave

Overview:
- Receive end of the 4-slot time-multiplexed sample stream carried on the fast clock.
- Consumes one signed sample per valid beat, tagged by a start-of-frame marker on slot 0.
- Gathers NUM_CH consecutive slots into a shadow frame, then presents all channels in parallel with a one-cycle frame strobe.
- Detects and recovers from slot misalignment.

Parameters:
- DATA_W, 16, width of each signed sample.
- NUM_CH, 4, slots per frame (power of two, >=2).
- CH_W, 2, slot counter width, equal to log2(NUM_CH).
- TIMEOUT_CYC, 16, idle-cycle limit; used only when TDM_TIMEOUT_EN is defined.

Ports:
- Ex_Clock  in  1  single fast clock; all logic on its rising edge.
- Ex_Rst_n  in  1  asynchronous active-low reset.
- In_Valid  in  1  sample beat present this cycle.
- In_Sof    in  1  beat is slot 0 of a frame; ignored when In_Valid=0.
- In_Data   in  DATA_W  signed sample.
- Out_Data  out  NUM_CH*DATA_W  committed frame; slot k occupies bits [k*DATA_W +: DATA_W].
- Out_Frame_Valid  out  1  one-cycle pulse when Out_Data has just been updated.
- Sync_Err  out  1  one-cycle pulse on a detected misalignment.
- Locked  out  1  high after a good frame; low after reset or Sync_Err.

Behaviour:
- Reset: async assert clears all outputs to 0, the shadow to 0, the slot count to 0, and the state to HUNT.
- Beat definition: a beat is any cycle with In_Valid=1; cycles with In_Valid=0 change nothing (TDM_TIMEOUT_EN excepted).
- FSM states are HUNT and COLLECT.
- HUNT, beat with In_Sof=0: discarded; no error.
- HUNT, beat with In_Sof=1: shadow[0] <= In_Data; count <= 1; go to COLLECT.
- COLLECT, count=0 (slot 0 expected):
  - In_Sof=1: shadow[0] <= In_Data; count <= 1.
  - In_Sof=0: Sync_Err pulse; Locked <= 0; beat discarded; go to HUNT.
- COLLECT, 0 < count < NUM_CH-1:
  - In_Sof=0: shadow[count] <= In_Data; count++.
  - In_Sof=1 (early SOF): Sync_Err pulse; Locked <= 0; the partial frame is dropped; the beat is taken as a new slot 0 (shadow[0] <= In_Data, count <= 1); stay in COLLECT.
- COLLECT, count=NUM_CH-1 (last slot):
  - In_Sof=0: on this edge, Out_Data slots 0..NUM_CH-2 <= shadow and slot NUM_CH-1 <= In_Data. Also count wraps to 0, and Out_Frame_Valid and Locked go high on the following cycle. Stay in COLLECT.
  - In_Sof=1: handled as the early-SOF case above.
- Latency: Out_Data and Out_Frame_Valid are visible the cycle after the last slot's beat.
- Out_Data holds its value between frames and is never partially updated.
- Out_Frame_Valid and Sync_Err are mutually exclusive in any cycle.
- Back-to-back frames at In_Valid=1 every cycle give one Out_Frame_Valid every NUM_CH cycles.
- Samples are stored bit-exact; no arithmetic, rounding or sign change.
- Reset mid-frame: the partial frame is lost; the last committed Out_Data is cleared to 0.

Optional Feature:
- Macro: TDM_TIMEOUT_EN.
- When defined: an idle counter counts consecutive In_Valid=0 cycles while in COLLECT and clears on any beat. When it reaches TIMEOUT_CYC, the block pulses Sync_Err, clears Locked and count, and goes to HUNT. A beat arriving in the same cycle the counter would expire has priority; no timeout is raised.
- When undefined: there is no counter, and gaps of any length inside a frame are legal.

Decomposition:
- Package tdm_pkg holds the state enum (HUNT, COLLECT), default DATA_W and NUM_CH, and a function deriving CH_W from NUM_CH.
- No sub-module is needed: counter, shadow and FSM form one flat block of about 200 lines.
- The idle counter lives under the macro in the same module.

Test Plan:
1. Reset, then 4 beats with In_Sof on the first, data 16'h0001, 16'hFFFE, 16'h7FFF, 16'h8000 -> one cycle after the 4th beat, Out_Data={8000,7FFF,FFFE,0001}, Out_Frame_Valid=1 for 1 cycle, Locked=1.
2. Three such frames back-to-back at In_Valid=1 every cycle, then gaps of 3 idle cycles between beats -> one pulse every 4 beats, with correct data each frame; no Sync_Err without the macro.
3. Early SOF: sof, data 1, 2, then sof 9, 10, 11, 12 -> Sync_Err pulse on the 2nd SOF, no frame strobe for 1/2, then Out_Data={12,11,10,9}.
4. Missing SOF: after a good frame, a beat with In_Sof=0 -> Sync_Err, Locked=0, HUNT. Non-SOF beats are ignored until the next SOF, which resyncs.
5. Ex_Rst_n pulsed low mid-frame after 2 beats -> all outputs 0 immediately; the next full frame is received correctly.
6. With TDM_TIMEOUT_EN, TIMEOUT_CYC=16: SOF, then 16 idle cycles -> Sync_Err at idle cycle 16. With a beat on cycle 16, there is no error.
